// File: rtl/mesi_isc_broad_seq.sv
`default_nettype none
// ============================================================================
// Module   : mesi_isc_broad_seq
// Purpose  : Broadcast sequencer of the MESI inter-stage controller. Buffers
//            arbitrated broadcast requests in a small FIFO, and for each one,
//            in order, snoops every non-initiator CPU on the coherence bus,
//            collects their acks, then grants the initiator.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            broad_fifo_wr_i, broad_*_i - request write strobe and payload
//            broad_fifo_status_full_o   - internal FIFO full (back-pressure)
//            cbus_ack_array_i           - per-CPU ack, bit k = CPU k
//            cbus_cmd_array_o           - per-CPU command, slice k = CPU k
//            cbus_addr_o, broad_snoop_* - payload of the active transaction
//            busy_o                     - a transaction is in progress
// Revision : 1.0 - initial release
// ============================================================================
module mesi_isc_broad_seq #(
   parameter int CBUS_CMD_WIDTH       = 3,
   parameter int ADDR_WIDTH           = 32,
   parameter int BROAD_TYPE_WIDTH     = 2,
   parameter int BROAD_ID_WIDTH       = 7,
   parameter int BROAD_FIFO_SIZE      = 2,
   parameter int BROAD_FIFO_SIZE_LOG2 = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          broad_fifo_wr_i,
   input  logic [ADDR_WIDTH-1:0]         broad_addr_i,
   input  logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i,
   input  logic [1:0]                    broad_cpu_id_i,
   input  logic [BROAD_ID_WIDTH-1:0]     broad_id_i,
   output logic                          broad_fifo_status_full_o,
   input  logic [3:0]                    cbus_ack_array_i,
   output logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
   output logic [ADDR_WIDTH-1:0]         cbus_addr_o,
   output logic [BROAD_TYPE_WIDTH-1:0]   broad_snoop_type_o,
   output logic [1:0]                    broad_snoop_cpu_id_o,
   output logic [BROAD_ID_WIDTH-1:0]     broad_snoop_id_o,
   output logic                          busy_o
);

   localparam int ENTRY_W = ADDR_WIDTH + BROAD_TYPE_WIDTH + 2 + BROAD_ID_WIDTH;

   localparam logic [CBUS_CMD_WIDTH-1:0] c_cmd_nop      = CBUS_CMD_WIDTH'(0);
   localparam logic [CBUS_CMD_WIDTH-1:0] c_cmd_wr_snoop = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0] c_cmd_rd_snoop = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0] c_cmd_en_wr    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0] c_cmd_en_rd    = CBUS_CMD_WIDTH'(4);

   localparam logic [BROAD_TYPE_WIDTH-1:0] c_type_rd = BROAD_TYPE_WIDTH'(0);
   localparam logic [BROAD_TYPE_WIDTH-1:0] c_type_wr = BROAD_TYPE_WIDTH'(1);

   localparam logic [BROAD_FIFO_SIZE_LOG2:0]   c_cnt_full = (BROAD_FIFO_SIZE_LOG2+1)'(BROAD_FIFO_SIZE);
   localparam logic [BROAD_FIFO_SIZE_LOG2:0]   c_cnt_one  = (BROAD_FIFO_SIZE_LOG2+1)'(1);
   localparam logic [BROAD_FIFO_SIZE_LOG2-1:0] c_ptr_one  = BROAD_FIFO_SIZE_LOG2'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SNOOP = 2'd1,
      ST_GRANT = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ENTRY_W-1:0]              fifo_mem_q [BROAD_FIFO_SIZE];
   logic [BROAD_FIFO_SIZE_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [BROAD_FIFO_SIZE_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [BROAD_FIFO_SIZE_LOG2:0]   count_q,  count_d;

   state_t                          state_q,   state_d;
   logic [3:0]                      pending_q, pending_d;
   logic [ADDR_WIDTH-1:0]           addr_q,    addr_d;
   logic [BROAD_TYPE_WIDTH-1:0]     type_q,    type_d;
   logic [1:0]                      cpu_q,     cpu_d;
   logic [BROAD_ID_WIDTH-1:0]       id_q,      id_d;
   logic [4*CBUS_CMD_WIDTH-1:0]     cmd_q,     cmd_d;
   logic                            busy_q,    busy_d;

   // ------------------------------------------------------------------------
   // FIFO head decode
   // ------------------------------------------------------------------------
   logic [ENTRY_W-1:0]          head;
   logic [ADDR_WIDTH-1:0]       head_addr;
   logic [BROAD_TYPE_WIDTH-1:0] head_type;
   logic [1:0]                  head_cpu;
   logic [BROAD_ID_WIDTH-1:0]   head_id;
   logic                        fifo_push;
   logic                        fifo_pop;

   assign head      = fifo_mem_q[rd_ptr_q];
   assign head_id   = head[BROAD_ID_WIDTH-1:0];
   assign head_cpu  = head[BROAD_ID_WIDTH +: 2];
   assign head_type = head[BROAD_ID_WIDTH+2 +: BROAD_TYPE_WIDTH];
   assign head_addr = head[ENTRY_W-1 -: ADDR_WIDTH];

   // A write while full is dropped even if a pop happens in the same cycle.
   assign fifo_push = broad_fifo_wr_i && (count_q < c_cnt_full);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      addr_d    = addr_q;
      type_d    = type_q;
      cpu_d     = cpu_q;
      id_d      = id_q;
      fifo_pop  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               // The head is consumed even when its type is reserved, so a
               // reserved request simply vanishes without cbus activity.
               fifo_pop = 1'b1;
               if (head_type == c_type_rd || head_type == c_type_wr) begin
                  state_d   = ST_SNOOP;
                  pending_d = 4'b1111 & ~(4'b0001 << head_cpu);
                  addr_d    = head_addr;
                  type_d    = head_type;
                  cpu_d     = head_cpu;
                  id_d      = head_id;
               end
            end
         end
         ST_SNOOP: begin
            // Only pending bits can be cleared; the initiator is never pending.
            pending_d = pending_q & ~cbus_ack_array_i;
            if (pending_d == 4'b0000) begin
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (cbus_ack_array_i[cpu_q]) begin
               state_d   = ST_IDLE;
               pending_d = 4'b0000;
               addr_d    = '0;
               type_d    = '0;
               cpu_d     = '0;
               id_d      = '0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = 4'b0000;
            addr_d    = '0;
            type_d    = '0;
            cpu_d     = '0;
            id_d      = '0;
         end
      endcase

      wr_ptr_d = fifo_push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
      rd_ptr_d = fifo_pop  ? rd_ptr_q + c_ptr_one : rd_ptr_q;
      unique case ({fifo_push, fifo_pop})
         2'b10:   count_d = count_q + c_cnt_one;
         2'b01:   count_d = count_q - c_cnt_one;
         default: count_d = count_q;
      endcase

      // Commands are decoded from the next state so they land in flops and
      // line up with the state they belong to.
      cmd_d = '0;
      for (int k = 0; k < 4; k++) begin
         if (state_d == ST_SNOOP && pending_d[k]) begin
            cmd_d[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
               (type_d == c_type_wr) ? c_cmd_wr_snoop : c_cmd_rd_snoop;
         end else if (state_d == ST_GRANT && cpu_d == 2'(k)) begin
            cmd_d[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
               (type_d == c_type_wr) ? c_cmd_en_wr : c_cmd_en_rd;
         end else begin
            cmd_d[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = c_cmd_nop;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BROAD_FIFO_SIZE; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= ST_IDLE;
         pending_q <= 4'b0000;
         addr_q    <= '0;
         type_q    <= '0;
         cpu_q     <= '0;
         id_q      <= '0;
         cmd_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= {broad_addr_i, broad_type_i, broad_cpu_id_i, broad_id_i};
         end
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         pending_q <= pending_d;
         addr_q    <= addr_d;
         type_q    <= type_d;
         cpu_q     <= cpu_d;
         id_q      <= id_d;
         cmd_q     <= cmd_d;
         busy_q    <= busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign broad_fifo_status_full_o = (count_q == c_cnt_full);
   assign cbus_cmd_array_o         = cmd_q;
   assign cbus_addr_o              = addr_q;
   assign broad_snoop_type_o       = type_q;
   assign broad_snoop_cpu_id_o     = cpu_q;
   assign broad_snoop_id_o         = id_q;
   assign busy_o                   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mesi_isc_broad_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesi_isc_broad_seq
// Purpose  : Directed self-checking bench for mesi_isc_broad_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesi_isc_broad_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr  = 1'b0;
   logic [31:0] addr = '0;
   logic [1:0]  typ  = '0;
   logic [1:0]  cpu  = '0;
   logic [6:0]  id   = '0;
   logic [3:0]  ack  = '0;

   logic        full;
   logic [11:0] cmds;
   logic [31:0] s_addr;
   logic [1:0]  s_type;
   logic [1:0]  s_cpu;
   logic [6:0]  s_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   mesi_isc_broad_seq dut (
      .clk                      (clk),
      .rst                      (rst),
      .broad_fifo_wr_i          (wr),
      .broad_addr_i             (addr),
      .broad_type_i             (typ),
      .broad_cpu_id_i           (cpu),
      .broad_id_i               (id),
      .broad_fifo_status_full_o (full),
      .cbus_ack_array_i         (ack),
      .cbus_cmd_array_o         (cmds),
      .cbus_addr_o              (s_addr),
      .broad_snoop_type_o       (s_type),
      .broad_snoop_cpu_id_o     (s_cpu),
      .broad_snoop_id_o         (s_id),
      .busy_o                   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [31:0] a, input logic [1:0] t,
                           input logic [1:0] c, input logic [6:0] i);
      wr = 1'b1; addr = a; typ = t; cpu = c; id = i;
      tick();
      wr = 1'b0; addr = '0; typ = '0; cpu = '0; id = '0;
   endtask

   function automatic logic [11:0] snoop_vec(input logic [1:0] c, input logic w);
      logic [11:0] v;
      v = '0;
      for (int k = 0; k < 4; k++) begin
         if (k != int'(c)) v[k*3 +: 3] = w ? 3'd1 : 3'd2;
      end
      return v;
   endfunction

   function automatic logic [11:0] grant_vec(input logic [1:0] c, input logic w);
      logic [11:0] v;
      v = '0;
      v[c*3 +: 3] = w ? 3'd3 : 3'd4;
      return v;
   endfunction

   // Called in the first SNOOP cycle; runs the transaction to IDLE.
   task automatic run_txn(input string tag, input logic [1:0] c, input logic w,
                          input logic [6:0] i, input logic [31:0] a);
      check({tag, "_snoop_cmds"}, cmds, snoop_vec(c, w));
      check({tag, "_id"}, s_id, i);
      check({tag, "_addr"}, s_addr, a);
      check({tag, "_cpu"}, s_cpu, c);
      check({tag, "_busy"}, busy, 1'b1);
      ack = 4'hF & ~(4'b0001 << c);
      tick();
      ack = '0;
      check({tag, "_grant_cmds"}, cmds, grant_vec(c, w));
      ack = 4'b0001 << c;
      tick();
      ack = '0;
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_cmds"}, cmds, 12'h000);
   endtask

   initial begin
      // ---------------- 1. reset with random inputs ----------------
      rst = 1'b1;
      wr = 1'($urandom_range(0, 1)); addr = $urandom; typ = 2'($urandom);
      cpu = 2'($urandom); id = 7'($urandom); ack = 4'($urandom);
      tick();
      wr = 1'($urandom_range(0, 1)); addr = $urandom; ack = 4'($urandom);
      tick();
      check("rst_cmds", cmds, 12'h000);
      check("rst_full", full, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_addr", s_addr, 32'h0);
      check("rst_id", s_id, 7'h0);
      rst = 1'b0; wr = 1'b0; addr = '0; typ = '0; cpu = '0; id = '0; ack = '0;
      tick();
      check("post_rst_busy", busy, 1'b0);

      // ---------------- 2. RD from CPU2, staggered acks ----------------
      push_req(32'h0000_1000, 2'd0, 2'd2, 7'd5);      // edge N
      check("t2_n1_busy", busy, 1'b0);
      tick();                                          // cycle N+2
      check("t2_n2_cmds", cmds, 12'b010_000_010_010);
      check("t2_n2_addr", s_addr, 32'h0000_1000);
      check("t2_n2_id", s_id, 7'd5);
      check("t2_n2_type", s_type, 2'd0);
      tick();                                          // N+3
      ack = 4'b0001; tick(); ack = '0;                 // N+4
      check("t2_n4_cmds", cmds, 12'b010_000_010_000);
      ack = 4'b1000; tick(); ack = '0;                 // N+5
      check("t2_n5_cmds", cmds, 12'b000_000_010_000);
      ack = 4'b0010; tick(); ack = '0;                 // N+6 -> N+7 GRANT
      check("t2_n7_cmds", cmds, 12'b000_100_000_000);
      check("t2_n7_busy", busy, 1'b1);
      tick();                                          // N+8
      check("t2_n8_hold", cmds, 12'b000_100_000_000);
      tick();                                          // N+9
      ack = 4'b0100; tick(); ack = '0;                 // N+10
      check("t2_n10_busy", busy, 1'b0);
      check("t2_n10_cmds", cmds, 12'h000);
      check("t2_n10_addr", s_addr, 32'h0);

      // ---------------- 3. WR from CPU0, all acks at once ----------------
      push_req(32'hDEAD_BEEF, 2'd1, 2'd0, 7'h7F);
      tick();
      check("t3_snoop_cmds", cmds, 12'b001_001_001_000);
      check("t3_id", s_id, 7'h7F);
      ack = 4'b1110; tick(); ack = '0;
      check("t3_grant_cmds", cmds, 12'b000_000_000_011);
      ack = 4'b0001; tick(); ack = '0;
      check("t3_idle_busy", busy, 1'b0);

      // ---------------- 4. back-pressure ----------------
      push_req(32'h0000_A000, 2'd0, 2'd3, 7'd10);      // A
      tick();
      check("t4_a_snoop_id", s_id, 7'd10);
      push_req(32'h0000_B000, 2'd1, 2'd1, 7'd11);      // B
      check("t4_full_b", full, 1'b0);
      push_req(32'h0000_C000, 2'd0, 2'd0, 7'd12);      // C
      check("t4_full_c", full, 1'b1);
      push_req(32'h0000_D000, 2'd1, 2'd2, 7'd13);      // D, dropped
      check("t4_full_d", full, 1'b1);
      check("t4_a_still_snoop", cmds, snoop_vec(2'd3, 1'b0));
      ack = 4'b0111; tick(); ack = '0;
      check("t4_a_grant", cmds, grant_vec(2'd3, 1'b0));
      ack = 4'b1000; tick(); ack = '0;
      check("t4_a_idle", busy, 1'b0);
      tick();
      check("t4_full_after_pop", full, 1'b0);
      run_txn("t4_b", 2'd1, 1'b1, 7'd11, 32'h0000_B000);
      tick();
      run_txn("t4_c", 2'd0, 1'b0, 7'd12, 32'h0000_C000);
      tick(); tick();
      check("t4_no_d_busy", busy, 1'b0);
      check("t4_no_d_id", s_id, 7'd0);

      // ---------------- 5. spurious acks ----------------
      push_req(32'h0000_5000, 2'd0, 2'd1, 7'h21);
      tick();
      check("t5_snoop", cmds, 12'b010_010_000_010);
      ack = 4'b0010; tick();
      check("t5_init_ack_ignored", cmds, 12'b010_010_000_010);
      ack = 4'b0011; tick();
      check("t5_cpu0_cleared", cmds, 12'b010_010_000_000);
      ack = 4'b0011; tick();
      check("t5_reack_no_change", cmds, 12'b010_010_000_000);
      check("t5_busy", busy, 1'b1);
      ack = 4'b1111; tick();
      check("t5_grant", cmds, 12'b000_000_100_000);
      ack = 4'b1101; tick();
      check("t5_other_acks_ignored", cmds, 12'b000_000_100_000);
      ack = 4'b0010; tick(); ack = '0;
      check("t5_idle", busy, 1'b0);

      // ---------------- 6. reserved type ----------------
      push_req(32'h0000_6000, 2'd2, 2'd0, 7'h44);
      tick();
      check("t6_resv_busy", busy, 1'b0);
      check("t6_resv_cmds", cmds, 12'h000);
      check("t6_resv_addr", s_addr, 32'h0);
      tick();
      check("t6_resv_busy2", busy, 1'b0);
      push_req(32'h0000_6100, 2'd0, 2'd3, 7'h45);
      tick();
      run_txn("t6_next", 2'd3, 1'b0, 7'h45, 32'h0000_6100);

      // ---------------- 1b. reset during SNOOP ----------------
      push_req(32'h0000_3000, 2'd0, 2'd0, 7'h30);      // X
      push_req(32'h0000_3100, 2'd0, 2'd0, 7'h31);      // Y queued, X in SNOOP
      check("t1b_snoop_busy", busy, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("t1b_rst_cmds", cmds, 12'h000);
      check("t1b_rst_busy", busy, 1'b0);
      tick();
      check("t1b_fifo_flushed", busy, 1'b0);
      push_req(32'h0000_3200, 2'd1, 2'd1, 7'h32);
      tick();
      run_txn("t1b_first", 2'd1, 1'b1, 7'h32, 32'h0000_3200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
